nxn_game_engine: RTL and testbench

//  Parametrised successor to the 3x3 move maker. Referees an N x N tic-tac-toe

---
 rtl/nxn_game_engine.sv | 184 ++++++++++++++++++
 tb/tb_nxn_game_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nxn_game_engine.sv
// rtl/nxn_game_engine.sv - N x N tic-tac-toe referee with a scanning computer opponent
module nxn_win_check #(
  parameter int BOARD_N = 3
) (
  input  logic [BOARD_N*BOARD_N-1:0] board,
  output logic                       win
);
  logic [BOARD_N-1:0] rowFull;
  logic [BOARD_N-1:0] colFull;
  logic [BOARD_N-1:0] diagBits;
  logic [BOARD_N-1:0] antiBits;

  for (genvar r = 0; r < BOARD_N; r++) begin : g_line
    logic [BOARD_N-1:0] colBits;
    for (genvar c = 0; c < BOARD_N; c++) begin : g_col
      assign colBits[c] = board[c*BOARD_N + r];
    end
    assign rowFull[r]  = &board[r*BOARD_N +: BOARD_N];
    assign colFull[r]  = &colBits;
    assign diagBits[r] = board[r*BOARD_N + r];
    assign antiBits[r] = board[r*BOARD_N + BOARD_N - 1 - r];
  end

  assign win = (|rowFull) || (|colFull) || (&diagBits) || (&antiBits);
endmodule

module nxn_game_engine #(
  parameter int BOARD_N        = 3,
  parameter int IDX_W          = $clog2(BOARD_N*BOARD_N),
  parameter bit COMPUTER_FIRST = 1'b0
) (
  input  logic                       CLOCK_50,
  input  logic                       resetn,
  input  logic                       new_game,
  input  logic                       move_valid,
  input  logic [IDX_W-1:0]           move_idx,
  output logic                       move_ready,
  output logic                       move_err,
  output logic                       comp_move_valid,
  output logic [IDX_W-1:0]           comp_move_idx,
  output logic [BOARD_N*BOARD_N-1:0] x_board,
  output logic [BOARD_N*BOARD_N-1:0] o_board,
  output logic                       player_won,
  output logic                       computer_won,
  output logic                       game_draw,
  output logic                       busy
);
  localparam int CELLS = BOARD_N*BOARD_N;

  typedef enum logic [2:0] {
    USER_WAIT, CHECK_X, SCAN_WIN, SCAN_BLOCK, SCAN_FREE, PLACE_O, CHECK_O, DONE
  } stateT;

  stateT            state;
  logic [IDX_W-1:0] scanIdx;
  logic [CELLS-1:0] oneBit, occupied, scanBit, moveBit, placeBit;
  logic             xWin, oWin, xTryWin, oTryWin;
  logic             cellFree, scanHit, lastIdx, idxInRange, moveTaken, boardFull;

  assign oneBit     = {{(CELLS-1){1'b0}}, 1'b1};
  assign occupied   = x_board | o_board;
  assign scanBit    = oneBit << scanIdx;
  assign moveBit    = oneBit << move_idx;
  assign placeBit   = oneBit << comp_move_idx;
  assign cellFree   = ~|(occupied & scanBit);
  assign lastIdx    = (scanIdx == IDX_W'(CELLS-1));
  assign idxInRange = ({1'b0, move_idx} < (IDX_W+1)'(CELLS));
  assign moveTaken  = |(occupied & moveBit);
  assign boardFull  = &occupied;

  nxn_win_check #(.BOARD_N(BOARD_N)) uXWin    (.board(x_board),           .win(xWin));
  nxn_win_check #(.BOARD_N(BOARD_N)) uOWin    (.board(o_board),           .win(oWin));
  nxn_win_check #(.BOARD_N(BOARD_N)) uXTryWin (.board(x_board | scanBit), .win(xTryWin));
  nxn_win_check #(.BOARD_N(BOARD_N)) uOTryWin (.board(o_board | scanBit), .win(oTryWin));

  always_comb begin
    scanHit = 1'b0;
    case (state)
      SCAN_WIN:   scanHit = cellFree && oTryWin;
      SCAN_BLOCK: scanHit = cellFree && xTryWin;
      SCAN_FREE:  scanHit = cellFree;
      default:    scanHit = 1'b0;
    endcase
  end

  // move_ready/busy are registered, so they are set alongside every state change
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state           <= COMPUTER_FIRST ? SCAN_WIN : USER_WAIT;
      scanIdx         <= '0;
      x_board         <= '0;
      o_board         <= '0;
      comp_move_idx   <= '0;
      move_ready      <= 1'b0;
      move_err        <= 1'b0;
      comp_move_valid <= 1'b0;
      player_won      <= 1'b0;
      computer_won    <= 1'b0;
      game_draw       <= 1'b0;
      busy            <= 1'b0;
    end else if (new_game) begin
      state           <= COMPUTER_FIRST ? SCAN_WIN : USER_WAIT;
      scanIdx         <= '0;
      x_board         <= '0;
      o_board         <= '0;
      comp_move_idx   <= '0;
      move_ready      <= !COMPUTER_FIRST;
      move_err        <= 1'b0;
      comp_move_valid <= 1'b0;
      player_won      <= 1'b0;
      computer_won    <= 1'b0;
      game_draw       <= 1'b0;
      busy            <= COMPUTER_FIRST;
    end else begin
      move_err        <= 1'b0;
      comp_move_valid <= 1'b0;
      case (state)
        USER_WAIT: begin
          move_ready <= 1'b1;
          busy       <= 1'b0;
          if (move_valid && move_ready) begin
            if (!idxInRange || moveTaken) begin
              move_err <= 1'b1;
            end else begin
              x_board    <= x_board | moveBit;
              state      <= CHECK_X;
              move_ready <= 1'b0;
              busy       <= 1'b1;
            end
          end
        end
        CHECK_X: begin
          if (xWin) begin
            player_won <= 1'b1;
            state      <= DONE;
            busy       <= 1'b0;
          end else if (boardFull) begin
            game_draw <= 1'b1;
            state     <= DONE;
            busy      <= 1'b0;
          end else begin
            scanIdx <= '0;
            state   <= SCAN_WIN;
          end
        end
        SCAN_WIN, SCAN_BLOCK, SCAN_FREE: begin
          busy <= 1'b1;
          if (scanHit) begin
            comp_move_idx <= scanIdx;
            state         <= PLACE_O;
          end else if (lastIdx) begin
            scanIdx <= '0;
            state   <= (state == SCAN_WIN) ? SCAN_BLOCK : SCAN_FREE;
          end else begin
            scanIdx <= scanIdx + IDX_W'(1);
          end
        end
        PLACE_O: begin
          o_board         <= o_board | placeBit;
          comp_move_valid <= 1'b1;
          state           <= CHECK_O;
        end
        CHECK_O: begin
          busy <= 1'b0;
          if (oWin) begin
            computer_won <= 1'b1;
            state        <= DONE;
          end else if (boardFull) begin
            game_draw <= 1'b1;
            state     <= DONE;
          end else begin
            move_ready <= 1'b1;
            state      <= USER_WAIT;
          end
        end
        DONE: begin
          move_ready <= 1'b0;
          busy       <= 1'b0;
        end
        default: state <= USER_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_nxn_game_engine.sv
// tb/tb_nxn_game_engine.sv - directed and random games against a cell-array reference model
module tb_nxn_game_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, newGame, moveValid, sel4;
  logic [3:0] moveIdx;
  logic       mv3, mv4;
  assign mv3 = moveValid & ~sel4;
  assign mv4 = moveValid & sel4;

  logic       mr3, me3, cv3, pw3, cw3, gd3, b3;
  logic [3:0] ci3;
  logic [8:0] xb3, ob3;
  logic       mr4, me4, cv4, pw4, cw4, gd4, b4;
  logic [3:0] ci4;
  logic [15:0] xb4, ob4;

  nxn_game_engine #(.BOARD_N(3)) dut3 (
    .CLOCK_50(clk), .resetn(resetn), .new_game(newGame), .move_valid(mv3), .move_idx(moveIdx),
    .move_ready(mr3), .move_err(me3), .comp_move_valid(cv3), .comp_move_idx(ci3),
    .x_board(xb3), .o_board(ob3), .player_won(pw3), .computer_won(cw3), .game_draw(gd3), .busy(b3));

  nxn_game_engine #(.BOARD_N(4)) dut4 (
    .CLOCK_50(clk), .resetn(resetn), .new_game(newGame), .move_valid(mv4), .move_idx(moveIdx),
    .move_ready(mr4), .move_err(me4), .comp_move_valid(cv4), .comp_move_idx(ci4),
    .x_board(xb4), .o_board(ob4), .player_won(pw4), .computer_won(cw4), .game_draw(gd4), .busy(b4));

  logic        obReady, obErr, obCv, obPw, obCw, obGd, obBusy;
  logic [3:0]  obCi;
  logic [15:0] obX, obO;
  assign obReady = sel4 ? mr4 : mr3;
  assign obErr   = sel4 ? me4 : me3;
  assign obCv    = sel4 ? cv4 : cv3;
  assign obPw    = sel4 ? pw4 : pw3;
  assign obCw    = sel4 ? cw4 : cw3;
  assign obGd    = sel4 ? gd4 : gd3;
  assign obBusy  = sel4 ? b4  : b3;
  assign obCi    = sel4 ? ci4 : ci3;
  assign obX     = sel4 ? xb4 : {7'b0, xb3};
  assign obO     = sel4 ? ob4 : {7'b0, ob3};

  int compared = 0;
  int mismatched = 0;

  // Reference model: 0 free, 1 X, 2 O
  int mcell[16];
  int mn;
  bit mDone, mPw, mCw, mDraw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit mWin(int p);
    bit line;
    for (int r = 0; r < mn; r++) begin
      line = 1;
      for (int c = 0; c < mn; c++) if (mcell[r*mn+c] != p) line = 0;
      if (line) return 1;
    end
    for (int c = 0; c < mn; c++) begin
      line = 1;
      for (int r = 0; r < mn; r++) if (mcell[r*mn+c] != p) line = 0;
      if (line) return 1;
    end
    line = 1;
    for (int i = 0; i < mn; i++) if (mcell[i*mn+i] != p) line = 0;
    if (line) return 1;
    line = 1;
    for (int i = 0; i < mn; i++) if (mcell[i*mn+mn-1-i] != p) line = 0;
    return line;
  endfunction

  function automatic bit mFull();
    for (int i = 0; i < mn*mn; i++) if (mcell[i] == 0) return 0;
    return 1;
  endfunction

  function automatic logic [15:0] mBoard(int p);
    logic [15:0] b = '0;
    for (int i = 0; i < mn*mn; i++) if (mcell[i] == p) b[i] = 1'b1;
    return b;
  endfunction

  // Win first, then block, then lowest free cell
  function automatic int mChoose();
    bit w;
    for (int pass = 0; pass < 3; pass++) begin
      for (int i = 0; i < mn*mn; i++) begin
        if (mcell[i] == 0) begin
          if (pass == 2) return i;
          mcell[i] = (pass == 0) ? 2 : 1;
          w = mWin((pass == 0) ? 2 : 1);
          mcell[i] = 0;
          if (w) return i;
        end
      end
    end
    return -1;
  endfunction

  task automatic mClear();
    for (int i = 0; i < 16; i++) mcell[i] = 0;
    mDone = 0; mPw = 0; mCw = 0; mDraw = 0;
  endtask

  task automatic checkState(input string tag);
    chk({tag, " x_board"}, obX, mBoard(1));
    chk({tag, " o_board"}, obO, mBoard(2));
    chk({tag, " player_won"}, obPw, mPw);
    chk({tag, " computer_won"}, obCw, mCw);
    chk({tag, " game_draw"}, obGd, mDraw);
    chk({tag, " move_ready"}, obReady, !mDone);
    chk({tag, " busy"}, obBusy, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("rst move_ready", obReady, 0);
    chk("rst busy", obBusy, 0);
    chk("rst comp_valid", obCv, 0);
    chk("rst comp_idx", obCi, 0);
    chk("rst boards", {obX, obO}, 0);
    chk("rst flags", {obPw, obCw, obGd, obErr}, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    mClear();
    checkState("post_reset");
  endtask

  task automatic doNewGame();
    @(negedge clk);
    newGame = 1'b1;
    @(negedge clk);
    newGame = 1'b0;
    mClear();
    checkState("new_game");
  endtask

  task automatic humanMove(input int idx, output int gotO);
    bit bad;
    int lat, expO;
    gotO = -1;
    bad = (idx >= mn*mn);
    if (!bad) bad = (mcell[idx] != 0);
    @(negedge clk);
    moveValid = 1'b1;
    moveIdx = 4'(idx);
    @(negedge clk);
    moveValid = 1'b0;
    chk("move_err", obErr, bad && !mDone);
    if (mDone || bad) begin
      checkState("rejected");
      return;
    end
    mcell[idx] = 1;
    if (mWin(1) || mFull()) begin
      mPw = mWin(1);
      mDraw = !mPw;
      mDone = 1;
      @(negedge clk);
      chk("no O after end", obCv, 0);
    end else begin
      lat = 0;
      while (!obCv && lat < 200) begin
        @(negedge clk);
        lat++;
        moveValid = 1'($urandom_range(0, 1));
        moveIdx = 4'($urandom_range(0, 15));
      end
      chk("latency bound", lat <= 3*mn*mn+2, 1);
      expO = mChoose();
      chk("comp_move_idx", obCi, expO);
      gotO = int'(obCi);
      if (expO >= 0) mcell[expO] = 2;
      chk("o_board at place", obO, mBoard(2));
      @(negedge clk);
      moveValid = 1'b0;
      chk("comp_valid single pulse", obCv, 0);
      if (mWin(2)) begin
        mCw = 1; mDone = 1;
      end else if (mFull()) begin
        mDraw = 1; mDone = 1;
      end
    end
    checkState("after move");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int o;
    int idx;
    int freeQ[$];
    resetn = 1'b0; newGame = 1'b0; moveValid = 1'b0; moveIdx = '0; sel4 = 1'b0;
    mn = 3;
    mClear();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // T1: reset while the computer is in its block scan
    doNewGame();
    @(negedge clk); moveValid = 1'b1; moveIdx = 4'd4;
    @(negedge clk); moveValid = 1'b0;
    repeat (12) @(negedge clk);
    chk("T1 busy mid-scan", obBusy, 1);
    doReset();

    // T2
    doNewGame();
    humanMove(4, o); chk("T2 reply", o, 0);

    // T3 + T6 (rejected moves)
    doNewGame();
    humanMove(4, o); chk("T3 reply1", o, 0);
    humanMove(3, o); chk("T3 reply2", o, 5);
    humanMove(4, o); chk("T6 occupied X", o, -1);
    humanMove(0, o); chk("T6 occupied O", o, -1);
    humanMove(9, o); chk("T6 out of range", o, -1);

    // T4
    doNewGame();
    humanMove(4, o); chk("T4 reply1", o, 0);
    humanMove(8, o); chk("T4 reply2", o, 1);
    humanMove(6, o); chk("T4 reply3", o, 2);
    chk("T4 computer_won", obCw, 1);
    humanMove(7, o);

    // T5
    doNewGame();
    humanMove(4, o); chk("T5 reply1", o, 0);
    humanMove(8, o); chk("T5 reply2", o, 1);
    humanMove(2, o); chk("T5 reply3", o, 5);
    humanMove(6, o); chk("T5 no reply", o, -1);
    chk("T5 player_won", obPw, 1);

    // Random 3x3 games, mixing in illegal offers
    for (int g = 0; g < 8; g++) begin
      doNewGame();
      for (int k = 0; k < 25 && !mDone; k++) begin
        if ($urandom_range(0, 4) == 0) idx = $urandom_range(0, 15);
        else begin
          freeQ.delete();
          for (int i = 0; i < mn*mn; i++) if (mcell[i] == 0) freeQ.push_back(i);
          idx = freeQ[$urandom_range(0, freeQ.size()-1)];
        end
        humanMove(idx, o);
      end
      humanMove($urandom_range(0, 8), o);
    end

    // N=4: fork forces O to block 10, leaving row 12..15 open
    sel4 = 1'b1;
    mn = 4;
    doNewGame();
    humanMove(2, o);  chk("N4 reply1", o, 0);
    humanMove(6, o);  chk("N4 reply2", o, 1);
    humanMove(12, o); chk("N4 reply3", o, 3);
    humanMove(13, o); chk("N4 reply4", o, 4);
    humanMove(14, o); chk("N4 reply5", o, 10);
    humanMove(15, o); chk("N4 no reply", o, -1);
    chk("N4 player_won", obPw, 1);

    for (int g = 0; g < 3; g++) begin
      doNewGame();
      for (int k = 0; k < 30 && !mDone; k++) begin
        freeQ.delete();
        for (int i = 0; i < mn*mn; i++) if (mcell[i] == 0) freeQ.push_back(i);
        idx = freeQ[$urandom_range(0, freeQ.size()-1)];
        humanMove(idx, o);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
